// File: rtl/spawn_pkg.sv
// Shared types and default constants for the spawn scheduler.
// Optional feature macro: SPAWN_NO_REPEAT_EN (see lane_picker / spawn_scheduler).
package spawn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PICK  = 2'd2,
    OFFER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KIND_ROCK    = 2'd0,
    KIND_COIN    = 2'd1,
    KIND_ENEMY   = 2'd2,
    KIND_POWERUP = 2'd3
  } kind_t;

  localparam int DEF_NUM_LANES  = 5;
  localparam int DEF_LANE_W     = 3;
  localparam int DEF_BASE_TICKS = 12;
  localparam int DEF_MAX_TRIES  = 8;

  // Countdown reload: base plus the LFSR high nibble, widened so it never wraps.
  function automatic logic [8:0] countdown_load(input logic [7:0] base, input logic [3:0] jitter);
    return {1'b0, base} + {5'b0, jitter};
  endfunction

endpackage

// File: rtl/lane_picker.sv
// Combinational lane decision for one rejection-sampling attempt.
// Accepts an in-range candidate; otherwise, once the attempt budget is spent,
// substitutes the fallback lane. With SPAWN_NO_REPEAT_EN defined the previous
// lane is also rejected and the fallback steers away from it.
module lane_picker
  import spawn_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int LANE_W    = DEF_LANE_W,
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic [LANE_W-1:0] candidate,
`ifdef SPAWN_NO_REPEAT_EN
  input  logic [LANE_W-1:0] last_lane,
`endif
  input  logic [3:0]        tries,
  output logic              take,
  output logic [LANE_W-1:0] lane
);

  localparam logic [LANE_W:0] LANE_LIMIT = (LANE_W+1)'(NUM_LANES);
  // The attempt that would bring tries up to MAX_TRIES is the last one.
  localparam logic [3:0]      LAST_TRY   = 4'(MAX_TRIES - 1);

  logic              in_range;
  logic              legal;
  logic              out_of_tries;
  logic [LANE_W-1:0] fallback;

  // Comparing at LANE_W+1 bits keeps the test unbiased even when NUM_LANES == 2**LANE_W.
  assign in_range = {1'b0, candidate} < LANE_LIMIT;

`ifdef SPAWN_NO_REPEAT_EN
  assign legal    = in_range && (candidate != last_lane);
  assign fallback = (last_lane == '0) ? LANE_W'(1) : '0;
`else
  assign legal    = in_range;
  assign fallback = '0;
`endif

  assign out_of_tries = (tries == LAST_TRY);
  assign take         = legal | out_of_tries;
  assign lane         = legal ? candidate : fallback;

endmodule

// File: rtl/spawn_scheduler.sv
// Spawn scheduler: waits a randomised number of game ticks, picks an unbiased
// random lane by rejection sampling and offers {lane, kind} over valid/ready.
// Optional feature macro: SPAWN_NO_REPEAT_EN (consecutive spawns never share a lane).
module spawn_scheduler
  import spawn_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int LANE_W     = DEF_LANE_W,
  parameter int BASE_TICKS = DEF_BASE_TICKS,
  parameter int MAX_TRIES  = DEF_MAX_TRIES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tick,
  input  logic [7:0]        rnd,
  output logic              spawn_valid,
  input  logic              spawn_ready,
  output logic [LANE_W-1:0] spawn_lane,
  output logic [1:0]        spawn_kind,
  output logic              busy
);

  localparam logic [7:0] BASE_T = 8'(BASE_TICKS);

  state_t            state_reg;
  logic [8:0]        countdown_reg;
  logic [3:0]        tries_reg;
  logic              valid_reg;
  logic [LANE_W-1:0] lane_reg;
  logic [1:0]        kind_reg;
`ifdef SPAWN_NO_REPEAT_EN
  logic [LANE_W-1:0] last_lane_reg;
`endif

  logic              pick_take;
  logic [LANE_W-1:0] pick_lane;
  logic [8:0]        load_value;
  logic              unused_rnd_bits;

  // Only some LFSR bits feed the lane/kind/jitter fields; the rest are deliberately dropped.
  assign unused_rnd_bits = ^rnd;
  assign load_value      = countdown_load(BASE_T, rnd[7:4]);

  lane_picker #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W),
    .MAX_TRIES (MAX_TRIES)
  ) u_lane_picker (
    .candidate (rnd[LANE_W-1:0]),
`ifdef SPAWN_NO_REPEAT_EN
    .last_lane (last_lane_reg),
`endif
    .tries     (tries_reg),
    .take      (pick_take),
    .lane      (pick_lane)
  );

  // Scheduler FSM: IDLE -> WAIT (tick countdown) -> PICK (sampling) -> OFFER (handshake).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      countdown_reg <= '0;
      tries_reg     <= '0;
      valid_reg     <= 1'b0;
      lane_reg      <= '0;
      kind_reg      <= '0;
`ifdef SPAWN_NO_REPEAT_EN
      last_lane_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (en) begin
            state_reg     <= WAIT;
            countdown_reg <= load_value;
          end
        end
        WAIT: begin
          if (!en) begin
            state_reg <= IDLE;
          end else if (tick) begin
            if (countdown_reg != '0) begin
              countdown_reg <= countdown_reg - 9'd1;
            end else begin
              state_reg <= PICK;
              tries_reg <= '0;
            end
          end
        end
        PICK: begin
          if (!en) begin
            state_reg <= IDLE;
          end else if (pick_take) begin
            lane_reg  <= pick_lane;
            kind_reg  <= rnd[7:6];
            valid_reg <= 1'b1;
            state_reg <= OFFER;
          end else begin
            tries_reg <= tries_reg + 4'd1;
          end
        end
        OFFER: begin
          // An offer is never retracted: only the handshake leaves this state.
          if (spawn_ready) begin
            valid_reg <= 1'b0;
`ifdef SPAWN_NO_REPEAT_EN
            last_lane_reg <= lane_reg;
`endif
            if (en) begin
              state_reg     <= WAIT;
              countdown_reg <= load_value;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign spawn_valid = valid_reg;
  assign spawn_lane  = lane_reg;
  assign spawn_kind  = kind_reg;
  assign busy        = (state_reg != IDLE);

endmodule
